instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Program loader that fills the pipeline's instruction memory before execution. It accepts a byte stream over a valid/ready handshake, reads a 16-bit word-count header, and packs the following bytes big-endian into 32-bit instructions. Each instruction is written at byte address 4·index, matching PC stepping. Instruction fetch only reads this memory; this block is its write side. It also holds the PC/pipeline until a load completes.

## Interface
- ADDR_W, 8, word-address width; memory holds 2^ADDR_W instructions
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  one-cycle pulse that begins a load; ignored while busy
- byteIn  in  8  stream byte
- byteValid  in  1  byteIn valid this cycle
- byteReady  out  1  loader accepts byte this cycle
- memWe  out  1  instruction-memory write strobe, one cycle per word
- memAddr  out  32  byte address of the write, always a multiple of 4
- memData  out  32  instruction to write
- busy  out  1  load in progress
- done  out  1  last load completed successfully
- error  out  1  last load rejected: bad header
- cpuHold  out  1  hold PC and pipeline buffers while high

## Operation
- A byte transfers on a rising edge with byteValid && byteReady.
- FSM states:
  - IDLE: byteReady=0; start → HDR0, clears done and error.
  - HDR0: accepts count[15:8] → HDR1.
  - HDR1: accepts count[7:0]. If count==0 or count>2^ADDR_W → ERR, else → DATA.
  - DATA: accepts 4 bytes, MSB first, into a shift register. The 4th accepted byte → WRITE.
  - WRITE: memWe=1, byteReady=0, memAddr={index,2'b00} zero-extended, memData=assembled word. Index increments. If index+1==count → DONE, else → DATA.
  - DONE: done=1, cpuHold=0, busy=0; start → HDR0.
  - ERR: error=1, cpuHold=1, busy=0; start → HDR0.
- busy=1 in HDR0, HDR1, DATA, WRITE.
- cpuHold=1 in every state except DONE, and goes back to 1 as soon as a new start is accepted.
- Index is ADDR_W+1 bits wide and never wraps; a load of exactly 2^ADDR_W words ends at index 2^ADDR_W−1.
- A start pulse in HDR0/HDR1/DATA/WRITE is ignored.
- There is no timeout. byteValid low simply stalls the state machine.
- Bytes presented while byteReady=0 are not consumed; the source must hold them.

## Timing
- Reset values (async on rst_n low): state IDLE, byteReady=0, memWe=0, memAddr=0, memData=0, busy=0, done=0, error=0, cpuHold=1.
- All outputs are registered or decoded from state only. No combinational path from byteValid or byteIn to any output.
- start accepted at edge N → HDR0 from N; byteReady=1 in cycle N+1.
- Fastest word with byteValid held high: 4 accept cycles + 1 WRITE cycle, i.e. 5 cycles per word.
- Minimum full load: 2 header cycles + 5·count cycles after start.
- memWe is high exactly one cycle per word; memAddr and memData are stable during that cycle.
- done/cpuHold change on the edge that leaves the final WRITE.
- rst_n asserted mid-load aborts immediately: outputs go to reset values and words already written stay in memory.
- rst_n deassertion is synchronised externally; the block samples it only through its async flops.

## Structure
- The shared constants header holds:
  - state encodings (IDLE..ERR, 3 bits)
  - header width (16)
  - the word-to-byte address shift (2), reused by PC logic.
- Natural sub-module: byte_packer. It is the 4-byte shift register plus 2-bit byte counter, with a word_ready flag; it is cleared in IDLE/HDR0.
- The state machine, index counter and header register stay in instr_mem_loader.

## Test plan
- Reset values: reset, then start, count=2, bytes 20 08 00 05 / 8C 09 00 04 with byteValid always high → writes 0x20080005@0x0 and 0x8C090004@0x4. done=1 and cpuHold=0 exactly 12 cycles after start.
- Source stalls: same load with byteValid toggling every other cycle → identical writes, no duplicate or skipped bytes, memWe count=2.
- Bad header: count=0 → error=1, cpuHold=1, no memWe. Count=257 with ADDR_W=8 → same.
- Full memory: count=256 → last write at 0x3FC, done=1, index does not wrap to 0x000.
- Reset mid-load: rst_n low during DATA of word 3 → all outputs at reset values that cycle. A new start then reloads from address 0.
- Start ignored while busy: start pulse during DATA → no state change, load completes normally.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// ============================================================================
// Module   : instr_mem_loader_pkg
// Brief    : Shared state encodings and constants for the instruction loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int c_HDR_W = 16;
  // Word index to byte address; the PC logic steps by the same amount.
  localparam int c_ADDR_SHIFT = 2;

  function automatic logic isBusy(input state_t s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_WRITE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader_byte_packer.sv
// ============================================================================
// Module   : instr_mem_loader_byte_packer
// Brief    : Big-endian 4-byte shift register with a 2-bit byte counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shiftEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        wordReady
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (shiftEn) begin
      r_word <= {r_word[23:0], byteIn};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  // High on the shift that delivers the fourth byte of a word.
  assign wordReady = shiftEn && (r_cnt == 2'd3);
  assign word      = r_word;

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module   : instr_mem_loader
// Brief    : Loads a counted byte stream into instruction memory, holding the CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memData,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpuHold
);

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W:0]      r_index;
  logic [7:0]           r_countHi;
  logic [c_HDR_W-1:0]   r_count;
  logic [c_HDR_W-1:0]   w_hdr;
  logic                 w_accept;
  logic                 w_hdrBad;
  logic                 w_lastWord;
  logic                 w_wordReady;
  logic                 w_packClear;
  logic                 w_shiftEn;
  logic [31:0]          w_word;
  logic                 r_byteReady;
  logic                 r_memWe;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic                 r_cpuHold;

  assign w_accept    = byteValid && r_byteReady;
  assign w_hdr       = {r_countHi, byteIn};
  assign w_hdrBad    = (w_hdr == '0) || (32'(w_hdr) > (32'd1 << ADDR_W));
  assign w_lastWord  = (32'(r_index) + 32'd1) == 32'(r_count);
  assign w_shiftEn   = w_accept && (r_state == ST_DATA);
  assign w_packClear = (r_state == ST_IDLE) || (r_state == ST_HDR0);

  instr_mem_loader_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_packClear),
    .shiftEn   (w_shiftEn),
    .byteIn    (byteIn),
    .word      (w_word),
    .wordReady (w_wordReady)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) w_next = ST_HDR0;
      ST_HDR0:  if (w_accept) w_next = ST_HDR1;
      ST_HDR1:  if (w_accept) w_next = w_hdrBad ? ST_ERR : ST_DATA;
      ST_DATA:  if (w_wordReady) w_next = ST_WRITE;
      ST_WRITE: w_next = w_lastWord ? ST_DONE : ST_DATA;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_countHi   <= '0;
      r_count     <= '0;
      r_byteReady <= 1'b0;
      r_memWe     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpuHold   <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_byteReady <= (w_next == ST_HDR0) || (w_next == ST_HDR1) || (w_next == ST_DATA);
      r_memWe     <= (w_next == ST_WRITE);
      r_busy      <= isBusy(w_next);
      r_done      <= (w_next == ST_DONE);
      r_error     <= (w_next == ST_ERR);
      r_cpuHold   <= (w_next != ST_DONE);

      // Index stays on the final word so a full load never wraps back to 0.
      if (((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR)) && start)
        r_index <= '0;
      else if ((r_state == ST_WRITE) && !w_lastWord)
        r_index <= r_index + (ADDR_W+1)'(1);

      if ((r_state == ST_HDR0) && w_accept) r_countHi <= byteIn;
      if ((r_state == ST_HDR1) && w_accept) r_count   <= w_hdr;
    end
  end

  assign byteReady = r_byteReady;
  assign memWe     = r_memWe;
  assign memAddr   = 32'(r_index) << c_ADDR_SHIFT;
  assign memData   = w_word;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign cpuHold   = r_cpuHold;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module   : tb_instr_mem_loader
// Brief    : Scoreboard bench for instr_mem_loader with directed load vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpuHold;

  instr_mem_loader #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byteIn    (byteIn),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memData   (memData),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpuHold   (cpuHold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] words[$];
  int          nChecks  = 0;
  int          nFails   = 0;
  int          nWrites  = 0;
  int          cyc      = 0;
  int          startCyc = 0;
  logic [31:0] lastAddr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe pops the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && memWe) begin
      nWrites++;
      lastAddr = memAddr;
      if (sbQ.size() == 0) begin
        check("unexpected write", 32'(sbQ.size()), 32'd1);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        check("memAddr", memAddr, e.addr);
        check("memData", memData, e.data);
      end
    end
  end

  task automatic pulseStart();
    @(negedge clk);
    start    = 1'b1;
    startCyc = cyc + 1;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit stall, input bit pulse);
    int guard;
    guard = 0;
    if (stall) begin
      @(negedge clk);
      byteValid = 1'b0;
      start     = 1'b0;
    end
    @(negedge clk);
    byteIn    = b;
    byteValid = 1'b1;
    start     = pulse;
    while (!byteReady && guard < 200) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
    end
    if (guard >= 200) check("byte accept timeout", 32'(guard), 32'd0);
  endtask

  task automatic sendHeader(input logic [15:0] cnt, input bit stall);
    sendByte(cnt[15:8], stall, 1'b0);
    sendByte(cnt[7:0], stall, 1'b0);
  endtask

  task automatic sendWords(input int n, input bit stall, input int pulseAt);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        w = words[i] >> (24 - 8 * b);
        sendByte(w[7:0], stall, (i * 4 + b) == pulseAt);
        if (b == 3) sbQ.push_back('{addr: 32'(i * 4), data: words[i]});
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    byteValid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int doneCyc);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    doneCyc = cyc;
    check("done reached", 32'(done), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " byteReady"}, 32'(byteReady), 32'd0);
    check({tag, " memWe"},     32'(memWe),     32'd0);
    check({tag, " memAddr"},   memAddr,        32'd0);
    check({tag, " memData"},   memData,        32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " done"},      32'(done),      32'd0);
    check({tag, " error"},     32'(error),     32'd0);
    check({tag, " cpuHold"},   32'(cpuHold),   32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int w0;
    logic [7:0] k;

    rst_n = 1'b0; start = 1'b0; byteIn = 8'h00; byteValid = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic two-word load at full rate.
    words = '{32'h2008_0005, 32'h8C09_0004};
    w0 = nWrites;
    pulseStart();
    sendHeader(16'd2, 1'b0);
    sendWords(2, 1'b0, -1);
    idle();
    waitDone(40, dc);
    check("done latency", 32'(dc - startCyc), 32'd12);
    check("cpuHold after done", 32'(cpuHold), 32'd0);
    check("busy after done", 32'(busy), 32'd0);
    check("writes basic", 32'(nWrites - w0), 32'd2);

    // Same load with the source stalling every other cycle.
    w0 = nWrites;
    pulseStart();
    sendHeader(16'd2, 1'b1);
    sendWords(2, 1'b1, -1);
    idle();
    waitDone(60, dc);
    check("writes stalled", 32'(nWrites - w0), 32'd2);

    // Bad headers: zero and one more than capacity.
    w0 = nWrites;
    pulseStart();
    sendHeader(16'd0, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    check("count0 error", 32'(error), 32'd1);
    check("count0 cpuHold", 32'(cpuHold), 32'd1);
    check("count0 busy", 32'(busy), 32'd0);
    check("count0 done", 32'(done), 32'd0);
    pulseStart();
    sendHeader(16'd257, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    check("count257 error", 32'(error), 32'd1);
    check("count257 cpuHold", 32'(cpuHold), 32'd1);
    check("bad header writes", 32'(nWrites - w0), 32'd0);

    // Fill all 256 words.
    words.delete();
    for (int i = 0; i < 256; i++) begin
      k = i[7:0];
      words.push_back({k, 8'h5A, ~k, 8'hC3});
    end
    w0 = nWrites;
    pulseStart();
    sendHeader(16'd256, 1'b0);
    check("error cleared on start", 32'(error), 32'd0);
    sendWords(256, 1'b0, -1);
    idle();
    waitDone(40, dc);
    check("full writes", 32'(nWrites - w0), 32'd256);
    check("full last addr", lastAddr, 32'h0000_03FC);
    check("full addr held", memAddr, 32'h0000_03FC);
    check("full latency", 32'(dc - startCyc), 32'd1282);

    // Reset during the third word, then reload from address 0.
    words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    pulseStart();
    sendHeader(16'd4, 1'b0);
    sendWords(2, 1'b0, -1);
    sendByte(8'h55, 1'b0, 1'b0);
    sendByte(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    byteValid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkResetOutputs("midload reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    words = '{32'hDEAD_BEEF};
    w0 = nWrites;
    pulseStart();
    sendHeader(16'd1, 1'b0);
    sendWords(1, 1'b0, -1);
    idle();
    waitDone(40, dc);
    check("reload writes", 32'(nWrites - w0), 32'd1);
    check("reload addr", lastAddr, 32'd0);

    // Start pulse during DATA must be ignored.
    words = '{32'h2008_0005, 32'h8C09_0004};
    w0 = nWrites;
    pulseStart();
    sendHeader(16'd2, 1'b0);
    sendWords(2, 1'b0, 2);
    idle();
    waitDone(40, dc);
    check("ignored start latency", 32'(dc - startCyc), 32'd12);
    check("ignored start writes", 32'(nWrites - w0), 32'd2);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
